// File: rtl/y86_pkg.sv
// Shared encodings for the Y86 pipeline controller.
// Icodes, register IDs, status codes, FSM states, hazard helper.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    // Load in E whose destination feeds a source read in D.
    function automatic logic load_use(
        input logic [3:0] e_icode,
        input logic [3:0] e_destm,
        input logic [3:0] src_a,
        input logic [3:0] src_b
    );
        return ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
               (e_destm != R_NONE) &&
               ((e_destm == src_a) || (e_destm == src_b));
    endfunction

endpackage

// File: rtl/perf_cnt.sv
// Free-running wrapping event counter.
// Ports: clk, rst_n (async low), i_en count enable, o_cnt value.
module perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (i_en) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline control: hazards, halt/drain FSM, single-step, perf counters.
// Ports: stage icodes/regs/status in; stall/bubble controls, step_ack, halted, counters out.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter bit          HALT_ON_MEM = 1'b1,
    parameter logic [2:0]  STAT_AOK    = S_AOK,
    parameter logic [2:0]  STAT_HLT    = S_HLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_destM,
    input  logic             e_cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic             dbg_en,
    input  logic             step_req,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             step_ack,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    if (STAT_HLT == STAT_AOK) begin : g_bad_stat
        $error("STAT_HLT must differ from STAT_AOK");
    end

    state_e r_state;
    logic   r_step_prev;
    logic   r_grant;

    logic w_lu;
    logic w_mp;
    logic w_ret;
    logic w_run;
    logic w_hold;
    logic w_mem_exc;
    logic w_wb_exc;

    assign w_lu  = load_use(E_icode, E_destM, d_srcA, d_srcB);
    assign w_mp  = (E_icode == I_JXX) && !e_cnd;
    assign w_ret = (D_icode == I_RET) || (E_icode == I_RET) ||
                   (M_icode == I_RET);

    assign w_run     = (r_state == ST_RUN);
    assign w_mem_exc = (m_stat != STAT_AOK);
    assign w_wb_exc  = (W_stat != STAT_AOK);

    // r_grant marks the cycle after a step_req rise was sampled.
    assign step_ack = r_grant && dbg_en && w_run;
    assign w_hold   = dbg_en && w_run && !r_grant;
    assign halted   = (r_state == ST_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_step_prev <= 1'b0;
            r_grant     <= 1'b0;
        end else begin
            r_step_prev <= step_req;
            r_grant     <= dbg_en && w_run && step_req && !r_step_prev;
            case (r_state)
                ST_RUN: begin
                    if (w_wb_exc) begin
                        r_state <= ST_HALTED;
                    end else if (HALT_ON_MEM && w_mem_exc) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_wb_exc) begin
                        r_state <= ST_HALTED;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        case (r_state)
            ST_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            ST_DRAIN: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            default: begin
                if (w_hold) begin
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    W_stall = 1'b1;
                end else if (w_lu) begin
                    // Load-use also covers a coincident ret.
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    E_bubble = 1'b1;
                end else if (w_mp) begin
                    D_bubble = 1'b1;
                    E_bubble = 1'b1;
                end else if (w_ret) begin
                    F_stall  = 1'b1;
                    D_bubble = 1'b1;
                end
            end
        endcase
    end

    perf_cnt #(.W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (!halted),
        .o_cnt (cyc_cnt)
    );

    perf_cnt #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_run && F_stall),
        .o_cnt (stall_cnt)
    );

    perf_cnt #(.W(CNT_W)) u_bubble (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_run && E_bubble),
        .o_cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl.
// Table vectors, directed corner sequences and random stimulus vs a model.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  D_icode, E_icode, M_icode;
    logic [3:0]  d_srcA, d_srcB, E_destM;
    logic        e_cnd;
    logic [2:0]  m_stat, W_stat;
    logic        dbg_en, step_req;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic        step_ack, halted;
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;

    logic        q_fs, q_ds, q_db, q_eb, q_mb, q_ws, q_ack, q_hl;
    logic [3:0]  q_cyc, q_stl, q_bub;

    logic [5:0]  ctrl;
    assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_destM(E_destM),
        .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
        .dbg_en(dbg_en), .step_req(step_req),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .step_ack(step_ack), .halted(halted),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl #(.CNT_W(4), .HALT_ON_MEM(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_destM(E_destM),
        .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
        .dbg_en(dbg_en), .step_req(step_req),
        .F_stall(q_fs), .D_stall(q_ds), .D_bubble(q_db),
        .E_bubble(q_eb), .M_bubble(q_mb), .W_stall(q_ws),
        .step_ack(q_ack), .halted(q_hl),
        .cyc_cnt(q_cyc), .stall_cnt(q_stl), .bubble_cnt(q_bub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_seen = 0;

    // Reference model: mode 0 running, 1 draining, 2 halted.
    int          m_mode;
    bit          m_prev;
    bit          m_gr;
    logic [31:0] m_cyc, m_stl, m_bub;

    typedef struct {
        logic [3:0] di, ei, mi, sa, sb, dm;
        logic       cnd;
        logic [5:0] exp;
    } vec_t;

    vec_t tab[11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] mdl_ctrl();
        bit lu, mp, rt;
        if (m_mode == 2) return 6'b110111;
        if (m_mode == 1) return 6'b101110;
        if (dbg_en && !m_gr) return 6'b110001;
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_destM != 4'hF &&
             (E_destM == d_srcA || E_destM == d_srcB);
        mp = (E_icode == 4'h7) && !e_cnd;
        rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        if (lu) return 6'b110100;
        if (mp) return 6'b001100;
        if (rt) return 6'b101000;
        return 6'b000000;
    endfunction

    task automatic set_in(input logic [3:0] di, ei, mi, sa, sb, dm,
                          input logic cnd);
        D_icode = di; E_icode = ei; M_icode = mi;
        d_srcA = sa; d_srcB = sb; E_destM = dm; e_cnd = cnd;
    endtask

    // One clock: check at negedge, advance model at posedge.
    task automatic tick(input bit tab_on = 1'b0,
                        input logic [5:0] tab_exp = 6'b0);
        logic [5:0] e;
        bit ea;
        @(negedge clk);
        e  = mdl_ctrl();
        ea = (m_mode == 0) && dbg_en && m_gr;
        chk("ctrl", 64'(ctrl), 64'(e));
        chk("step_ack", 64'(step_ack), 64'(ea));
        chk("halted", 64'(halted), 64'(m_mode == 2));
        chk("cyc_cnt", 64'(cyc_cnt), 64'(m_cyc));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stl));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        if (tab_on) chk("tab_ctrl", 64'(ctrl), 64'(tab_exp));
        if (step_ack) ack_seen++;
        @(posedge clk);
        if (m_mode != 2) m_cyc = m_cyc + 1;
        if (m_mode == 0 && e[5]) m_stl = m_stl + 1;
        if (m_mode == 0 && e[2]) m_bub = m_bub + 1;
        m_gr   = (m_mode == 0) && dbg_en && step_req && !m_prev;
        m_prev = step_req;
        if (m_mode != 2 && W_stat != 3'd1) m_mode = 2;
        else if (m_mode == 0 && m_stat != 3'd1) m_mode = 1;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_mode = 0; m_prev = 0; m_gr = 0;
        m_cyc = 0; m_stl = 0; m_bub = 0;
        chk("rst_cyc", 64'(cyc_cnt), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_ack", 64'(step_ack), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tab[0]  = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 6'b000000};
        tab[1]  = '{4'h0, 4'h5, 4'h0, 4'h3, 4'hF, 4'h3, 1'b1, 6'b110100};
        tab[2]  = '{4'h0, 4'hB, 4'h0, 4'h1, 4'h2, 4'h2, 1'b1, 6'b110100};
        tab[3]  = '{4'h0, 4'h5, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 6'b000000};
        tab[4]  = '{4'h0, 4'h7, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 6'b001100};
        tab[5]  = '{4'h0, 4'h7, 4'h0, 4'h1, 4'h2, 4'h3, 1'b1, 6'b000000};
        tab[6]  = '{4'h9, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 6'b101000};
        tab[7]  = '{4'h0, 4'h0, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 6'b101000};
        tab[8]  = '{4'h9, 4'h5, 4'h0, 4'h4, 4'hF, 4'h4, 1'b1, 6'b110100};
        tab[9]  = '{4'h0, 4'h7, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0, 6'b001100};
        tab[10] = '{4'h0, 4'h9, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 6'b101000};

        set_in(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1);
        m_stat = 3'd1; W_stat = 3'd1; dbg_en = 1'b0; step_req = 1'b0;
        do_reset();

        // Narrow counter wraps: 17 clocks -> 1.
        for (int i = 0; i < 17; i++) tick();
        #2;
        chk("cnt4_wrap", 64'(q_cyc), 64'd1);

        for (int i = 0; i < 11; i++) begin
            set_in(tab[i].di, tab[i].ei, tab[i].mi, tab[i].sa, tab[i].sb,
                   tab[i].dm, tab[i].cnd);
            tick(1'b1, tab[i].exp);
        end

        // Ret travelling D -> E -> M.
        set_in(4'h9, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1);
        tick(1'b1, 6'b101000);
        set_in(4'h0, 4'h9, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1);
        tick(1'b1, 6'b101000);
        set_in(4'h0, 4'h0, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1);
        tick(1'b1, 6'b101000);

        // Single-step with step_req held 5 cycles.
        set_in(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1);
        dbg_en = 1'b1;
        tick(1'b1, 6'b110001);
        ack_seen = 0;
        step_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        step_req = 1'b0;
        tick(1'b1, 6'b110001);
        chk("step_once", 64'(ack_seen), 64'd1);
        dbg_en = 1'b0;

        // Random run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] pick [6];
            pick = '{4'h0, 4'h5, 4'h7, 4'h9, 4'hB, 4'h2};
            D_icode = pick[$urandom_range(0, 5)];
            E_icode = pick[$urandom_range(0, 5)];
            M_icode = pick[$urandom_range(0, 5)];
            d_srcA  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            d_srcB  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            E_destM = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            e_cnd   = 1'($urandom_range(0, 1));
            if (i % 50 == 0) dbg_en = ~dbg_en;
            step_req = ($urandom_range(0, 3) == 0);
            tick();
        end
        dbg_en = 1'b0; step_req = 1'b0;

        // Memory exception, then writeback exception one cycle later.
        set_in(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1);
        m_stat = 3'd2;
        tick();
        m_stat = 3'd1; W_stat = 3'd2;
        #2;
        chk("drain_state", 64'(ctrl), 64'(6'b101110));
        chk("nomem_run", 64'(q_mb), 64'd0);
        tick();
        W_stat = 3'd1;
        #2;
        chk("halt_ctrl", 64'(ctrl), 64'(6'b110111));
        chk("halt_flag", 64'(halted), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        tick();
        chk("post_rst_cyc", 64'(cyc_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
